calc_sequencer: RTL and testbench

Multi-cycle arithmetic controller for the calculator datapath. It accepts one 16-bit unsigned operation (add, subtract, multiply or divide) through a start/busy/done handshake and sequences a single shared adder/subtractor. Add and subtract finish in one cycle; multiply uses iterative shift-and-add and divide uses restoring division, each over WIDTH cycles. Its registered result feeds the decimal digit decoder and display logic downstream.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_addsub.sv | 19 +
 rtl/calc_sequencer.sv | 149 ++++++++++++++
 tb/tb_calc_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic sequencer: op codes, FSM states
// and the iteration-counter sizing helper.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ITER = 2'b10
  } state_t;

  // Counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/calc_addsub.sv
// WIDTH-bit adder/subtractor; subtract is x + ~y + 1, so borrow is ~cout.
module calc_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] y_eff;

  always_comb begin
    y_eff = sub ? ~y : y;
    {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
  end

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle add/sub/mul/div controller sharing one adder; mul is shift-and-add,
// div is restoring division, both over WIDTH iterations.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             error
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] add_x;
  logic             add_sub;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] p_acc;
  logic             c_acc;
  logic             div_ok;
  logic [WIDTH-1:0] p_nx;
  logic [WIDTH-1:0] q_nx;

  calc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x    (add_x),
    .y    (b_r),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Operand multiplexing for the single shared adder.
  always_comb begin
    r_shift = {p_r[WIDTH-2:0], q_r[WIDTH-1]};
    add_x   = q_r;
    add_sub = 1'b0;
    case (state)
      EXEC: begin
        add_x   = q_r;
        add_sub = (op_r == OP_SUB);
      end
      ITER: begin
        if (op_r == OP_DIV) begin
          add_x   = r_shift;
          add_sub = 1'b1;
        end else begin
          add_x   = p_r;
        end
      end
      default: ;
    endcase
  end

  // Next accumulator for one iteration of mul or div.
  always_comb begin
    {c_acc, p_acc} = q_r[0] ? {add_cout, add_sum} : {1'b0, p_r};
    // A bit shifted out of R means the true remainder exceeds any divisor.
    div_ok = add_cout | p_r[WIDTH-1];
    if (op_r == OP_DIV) begin
      p_nx = div_ok ? add_sum : r_shift;
      q_nx = {q_r[WIDTH-2:0], div_ok};
    end else begin
      p_nx = {c_acc, p_acc[WIDTH-1:1]};
      q_nx = {p_acc[0], q_r[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_r   <= OP_ADD;
      p_r    <= '0;
      q_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      hi     <= '0;
      error  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op_t'(op);
            q_r  <= a;
            b_r  <= b;
            p_r  <= '0;
            cnt  <= CW'(WIDTH);
            busy <= 1'b1;
            case (op_t'(op))
              OP_MUL:  state <= ITER;
              OP_DIV:  state <= (b != '0) ? ITER : EXEC;
              default: state <= EXEC;
            endcase
          end
        end
        EXEC: begin
          if (op_r == OP_DIV) begin
            result <= '1;
            hi     <= q_r;
            error  <= 1'b1;
          end else begin
            result <= add_sum;
            hi     <= '0;
            error  <= (op_r == OP_SUB) ? ~add_cout : add_cout;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ITER: begin
          p_r <= p_nx;
          q_r <= q_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= q_nx;
            hi     <= p_nx;
            error  <= (op_r == OP_MUL) ? (p_nx != '0) : 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer with hand-computed expectations.
module tb_calc_sequencer;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             error;

  int unsigned n_checks;
  int unsigned n_errors;

  calc_sequencer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hi     (hi),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue at a negedge, accept on the next posedge, then count edges to done.
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input int lat, input logic [WIDTH-1:0] er,
                       input logic [WIDTH-1:0] eh, input logic ee);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'b00; a = '0; b = '0;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_hi"}, 32'(hi), 32'(eh));
    check({tag, "_error"}, 32'(error), 32'(ee));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    int lat;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_hi", 32'(hi), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_op("add_carry", 2'b00, 16'hFFFF, 16'h0002, 1, 16'h0001, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_held", 32'(result), 32'h0001);

    // Second sub is issued at the negedge inside the first one's done cycle.
    do_op("sub_borrow", 2'b01, 16'd5, 16'd9, 1, 16'hFFFC, 16'h0000, 1'b1);
    do_op("sub_b2b", 2'b01, 16'd9, 16'd5, 1, 16'd4, 16'h0000, 1'b0);

    do_op("mul_ovf", 2'b10, 16'd300, 16'd300, 16, 16'h5F90, 16'h0001, 1'b1);
    do_op("mul_small", 2'b10, 16'd123, 16'd45, 16, 16'd5535, 16'h0000, 1'b0);
    do_op("div_norm", 2'b11, 16'd1000, 16'd7, 16, 16'd142, 16'd6, 1'b0);
    do_op("div_big", 2'b11, 16'hFFFF, 16'hFFFE, 16, 16'd1, 16'd1, 1'b0);
    do_op("div_zero", 2'b11, 16'd42, 16'd0, 1, 16'hFFFF, 16'd42, 1'b1);

    // Repeated start pulses while a multiply is in flight must be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 16'd300; b = 16'd300;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0; dones = 0; lat = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      start = (n < 12) ? n[0] : 1'b0;
      op = 2'b00; a = 16'd1; b = 16'd1;
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        dones++;
        lat = n;
      end
    end
    start = 1'b0;
    check("mul_ignore_dones", 32'(dones), 32'd1);
    check("mul_ignore_latency", 32'(lat), 32'd16);
    check("mul_ignore_result", 32'(result), 32'h5F90);
    check("mul_ignore_hi", 32'(hi), 32'h0001);

    // Reset five cycles into a divide aborts it with no done.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 16'd1000; b = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_hi", 32'(hi), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (WIDTH + 2) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    do_op("add_after_reset", 2'b00, 16'd3, 16'd4, 1, 16'd7, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
